// File: rtl/ft8_pkg.sv
// ft8_pkg: constants and types shared by the FT8 modulator and deframer.
//   FT8_COSTAS      : 7-tone Costas sync pattern, index 0 = first symbol sent
//   FT8_GRAY_DECODE : tone index -> 3 data bits
//   NUM_SYMBOLS / SYNC_LEN / DATA_HALF / NUM_DATA / CW_BITS : frame geometry
//   deframe_state_t : deframer state encoding
//   sat_inc3        : 3-bit saturating increment for mismatch counters
package ft8_pkg;

    localparam int NUM_SYMBOLS = 79;
    localparam int SYNC_LEN    = 7;
    localparam int DATA_HALF   = 29;
    localparam int NUM_DATA    = NUM_SYMBOLS - 3 * SYNC_LEN;  // 58 data symbols
    localparam int CW_BITS     = 3 * NUM_DATA;                // 174

    // Packed so that FT8_COSTAS[i] is position i: 3,1,4,0,6,5,2.
    localparam logic [SYNC_LEN-1:0][2:0] FT8_COSTAS =
        {3'd2, 3'd5, 3'd6, 3'd0, 3'd4, 3'd1, 3'd3};

    // FT8_GRAY_DECODE[tone] = bits; 0->000 1->001 2->011 3->010 4->110 5->100 6->101 7->111.
    localparam logic [7:0][2:0] FT8_GRAY_DECODE =
        {3'b111, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_DATA1 = 3'd1,
        ST_SYNC2 = 3'd2,
        ST_DATA2 = 3'd3,
        ST_SYNC3 = 3'd4,
        ST_DONE  = 3'd5
    } deframe_state_t;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v, input logic inc);
        if (inc && (v != 3'd7)) return v + 3'd1;
        return v;
    endfunction

endpackage

// File: rtl/ft8_costas_match.sv
// ft8_costas_match: combinational count of positions where a 7-tone window
// differs from the Costas pattern.
//   window  in  [6:0][2:0]  window[0] is the oldest tone (Costas position 0)
//   err_cnt out [2:0]       number of mismatching positions, 0..7
module ft8_costas_match
    import ft8_pkg::*;
(
    input  logic [SYNC_LEN-1:0][2:0] window,
    output logic [2:0]               err_cnt
);

    always_comb begin
        err_cnt = '0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            if (window[i] != FT8_COSTAS[i]) err_cnt = err_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/ft8_symbol_deframer.sv
// ft8_symbol_deframer: hunts for the FT8 Costas sync in a stream of hard tone
// decisions, verifies the mid/end sync blocks and Gray-decodes the 58 data
// symbols into a 174-bit codeword handed off over valid/ready.
//   clk, reset_n            clock, asynchronous active-low reset
//   sym_valid/sym_tone      incoming tone index, accepted when sym_ready=1
//   sym_ready               low only while a finished codeword is waiting
//   cw_valid/cw_ready/cw    codeword handshake; cw[173] is the first data bit
//   sync_locked             high from hunt lock until handoff or abort
//   frame_abort             one-cycle pulse when S2/S3 has too many errors
// Optional build macro FT8_DEFRAME_STATS_EN adds:
//   sync_err_total [4:0]    S1+S2+S3 mismatches, valid with cw_valid
//   abort_count    [7:0]    wrapping count of frame_abort pulses
module ft8_symbol_deframer
    import ft8_pkg::*;
#(
    parameter int SYNC_MAX_ERR     = 1,
    parameter int SYNC_CHK_MAX_ERR = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sym_valid,
    input  logic [2:0]         sym_tone,
    output logic               sym_ready,
    output logic               cw_valid,
    input  logic               cw_ready,
    output logic [CW_BITS-1:0] cw,
    output logic               sync_locked,
    output logic               frame_abort
`ifdef FT8_DEFRAME_STATS_EN
    ,
    output logic [4:0]         sync_err_total,
    output logic [7:0]         abort_count
`endif
);

    localparam logic [2:0] HUNT_MAX = 3'(SYNC_MAX_ERR);
    localparam logic [2:0] CHK_MAX  = 3'(SYNC_CHK_MAX_ERR);

    deframe_state_t state_q, state_d;
    // Only the six older tones are stored; the incoming tone completes the
    // 7-entry hunt window so lock is decided on the accepting edge.
    logic [SYNC_LEN-2:0][2:0] window_q, window_d;
    logic [2:0]               fill_q, fill_d;
    logic [4:0]               cnt_q, cnt_d;     // data index in half, or sync position
    logic [2:0]               err_q, err_d;     // running S2/S3 mismatches
    logic [CW_BITS-1:0]       cw_q, cw_d;
    logic                     cw_valid_q, cw_valid_d;
    logic                     sync_locked_q, sync_locked_d;
    logic                     frame_abort_q, frame_abort_d;
    logic                     sym_ready_q, sym_ready_d;
`ifdef FT8_DEFRAME_STATS_EN
    logic [2:0]               s1_err_q, s1_err_d;
    logic [2:0]               s2_err_q, s2_err_d;
    logic [4:0]               err_total_q, err_total_d;
    logic [7:0]               abort_cnt_q, abort_cnt_d;
`endif

    logic                     acc;
    logic [SYNC_LEN-1:0][2:0] hunt_win;
    logic [2:0]               hunt_err;
    logic                     tone_miss;
    logic [2:0]               err_sum;
    logic [5:0]               data_idx;
    logic [2:0]               data_bits;
    logic                     wr_en;

    assign acc       = sym_valid & sym_ready_q;
    assign hunt_win  = {sym_tone, window_q};
    assign tone_miss = (sym_tone != FT8_COSTAS[cnt_q[2:0]]);
    assign err_sum   = sat_inc3(err_q, tone_miss);
    assign data_idx  = (state_q == ST_DATA2) ? (6'(cnt_q) + 6'(DATA_HALF)) : 6'(cnt_q);
    assign data_bits = FT8_GRAY_DECODE[sym_tone];

    ft8_costas_match u_hunt_match (
        .window  (hunt_win),
        .err_cnt (hunt_err)
    );

    always_comb begin
        state_d       = state_q;
        window_d      = window_q;
        fill_d        = fill_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        cw_d          = cw_q;
        cw_valid_d    = cw_valid_q;
        sync_locked_d = sync_locked_q;
        frame_abort_d = 1'b0;
        wr_en         = 1'b0;
`ifdef FT8_DEFRAME_STATS_EN
        s1_err_d      = s1_err_q;
        s2_err_d      = s2_err_q;
        err_total_d   = err_total_q;
        abort_cnt_d   = abort_cnt_q;
`endif

        unique case (state_q)
            ST_HUNT: begin
                if (acc) begin
                    window_d = hunt_win[SYNC_LEN-1:1];
                    fill_d   = (fill_q == 3'(SYNC_LEN)) ? fill_q : fill_q + 3'd1;
                    if ((fill_d == 3'(SYNC_LEN)) && (hunt_err <= HUNT_MAX)) begin
                        state_d       = ST_DATA1;
                        sync_locked_d = 1'b1;
                        cnt_d         = '0;
`ifdef FT8_DEFRAME_STATS_EN
                        s1_err_d      = hunt_err;
`endif
                    end
                end
            end

            ST_DATA1, ST_DATA2: begin
                if (acc) begin
                    wr_en = 1'b1;
                    if (cnt_q == 5'(DATA_HALF - 1)) begin
                        cnt_d   = '0;
                        err_d   = '0;
                        state_d = (state_q == ST_DATA1) ? ST_SYNC2 : ST_SYNC3;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end

            ST_SYNC2, ST_SYNC3: begin
                if (acc) begin
                    if (cnt_q == 5'(SYNC_LEN - 1)) begin
                        cnt_d = '0;
                        err_d = '0;
                        if (err_sum > CHK_MAX) begin
                            frame_abort_d = 1'b1;
                            sync_locked_d = 1'b0;
                            state_d       = ST_HUNT;
                            fill_d        = '0;
`ifdef FT8_DEFRAME_STATS_EN
                            abort_cnt_d   = abort_cnt_q + 8'd1;
`endif
                        end else if (state_q == ST_SYNC2) begin
                            state_d = ST_DATA2;
`ifdef FT8_DEFRAME_STATS_EN
                            s2_err_d = err_sum;
`endif
                        end else begin
                            state_d    = ST_DONE;
                            cw_valid_d = 1'b1;
`ifdef FT8_DEFRAME_STATS_EN
                            err_total_d = 5'(s1_err_q) + 5'(s2_err_q) + 5'(err_sum);
`endif
                        end
                    end else begin
                        err_d = err_sum;
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end

            ST_DONE: begin
                if (cw_valid_q && cw_ready) begin
                    cw_valid_d    = 1'b0;
                    sync_locked_d = 1'b0;
                    state_d       = ST_HUNT;
                    fill_d        = '0;
                end
            end

            default: state_d = ST_HUNT;
        endcase

        // In-place write of one 3-bit data slot; untouched slots keep old bits.
        for (int s = 0; s < NUM_DATA; s++) begin
            if (wr_en && (data_idx == 6'(s))) cw_d[CW_BITS-1-3*s -: 3] = data_bits;
        end

        sym_ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HUNT;
            window_q      <= '0;
            fill_q        <= '0;
            cnt_q         <= '0;
            err_q         <= '0;
            cw_q          <= '0;
            cw_valid_q    <= 1'b0;
            sync_locked_q <= 1'b0;
            frame_abort_q <= 1'b0;
            sym_ready_q   <= 1'b1;
`ifdef FT8_DEFRAME_STATS_EN
            s1_err_q      <= '0;
            s2_err_q      <= '0;
            err_total_q   <= '0;
            abort_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            window_q      <= window_d;
            fill_q        <= fill_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            cw_q          <= cw_d;
            cw_valid_q    <= cw_valid_d;
            sync_locked_q <= sync_locked_d;
            frame_abort_q <= frame_abort_d;
            sym_ready_q   <= sym_ready_d;
`ifdef FT8_DEFRAME_STATS_EN
            s1_err_q      <= s1_err_d;
            s2_err_q      <= s2_err_d;
            err_total_q   <= err_total_d;
            abort_cnt_q   <= abort_cnt_d;
`endif
        end
    end

    assign sym_ready   = sym_ready_q;
    assign cw_valid    = cw_valid_q;
    assign cw          = cw_q;
    assign sync_locked = sync_locked_q;
    assign frame_abort = frame_abort_q;
`ifdef FT8_DEFRAME_STATS_EN
    assign sync_err_total = err_total_q;
    assign abort_count    = abort_cnt_q;
`endif

endmodule

// File: tb/tb_ft8_symbol_deframer.sv
// Scoreboard bench for ft8_symbol_deframer: a frame-level reference model
// consumes every accepted tone and queues the expected lock/abort/codeword
// events; a negedge monitor pops and compares whenever the DUT shows one.
module tb_ft8_symbol_deframer;

    localparam int SME = 1;
    localparam int SCE = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         sym_valid = 1'b0;
    logic [2:0]   sym_tone = 3'd0;
    logic         sym_ready;
    logic         cw_valid;
    logic         cw_ready = 1'b1;
    logic [173:0] cw;
    logic         sync_locked;
    logic         frame_abort;
`ifdef FT8_DEFRAME_STATS_EN
    logic [4:0]   sync_err_total;
    logic [7:0]   abort_count;
`endif

    ft8_symbol_deframer #(.SYNC_MAX_ERR(SME), .SYNC_CHK_MAX_ERR(SCE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sym_valid   (sym_valid),
        .sym_tone    (sym_tone),
        .sym_ready   (sym_ready),
        .cw_valid    (cw_valid),
        .cw_ready    (cw_ready),
        .cw          (cw),
        .sync_locked (sync_locked),
        .frame_abort (frame_abort)
`ifdef FT8_DEFRAME_STATS_EN
        ,
        .sync_err_total (sync_err_total),
        .abort_count    (abort_count)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    // ---------------- reference model ----------------
    int costas[7] = '{3, 1, 4, 0, 6, 5, 2};
    logic [173:0] CLEAN = {{29{3'b011}}, {29{3'b100}}};

    function automatic logic [2:0] gray(input int t);
        case (t)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b011;
            3: return 3'b010;
            4: return 3'b110;
            5: return 3'b100;
            6: return 3'b101;
            default: return 3'b111;
        endcase
    endfunction

    typedef struct { logic [173:0] cw; int idx; int serr; } cw_exp_t;
    typedef struct { int idx; int acnt; } ab_exp_t;
    typedef struct { int idx; logic val; } lk_exp_t;
    cw_exp_t q_cw[$];
    ab_exp_t q_ab[$];
    lk_exp_t q_lk[$];

    int           m_locked;     // 0: hunting, 1: inside a frame
    int           m_fpos;       // frame position of the next symbol
    int           m_s1, m_s2, m_s3, m_aborts;
    int           m_hist[$];
    logic [173:0] m_cw;
    int           n_acc = 0;
    time          last_acc_t = 0;

    task automatic model_abort();
        m_aborts = (m_aborts + 1) % 256;
        q_ab.push_back('{idx: n_acc, acnt: m_aborts});
        q_lk.push_back('{idx: n_acc, val: 1'b0});
        m_locked = 0;
        m_hist.delete();
    endtask

    task automatic model_accept(input int t);
        int e, f;
        if (m_locked == 0) begin
            m_hist.push_back(t);
            if (m_hist.size() > 7) void'(m_hist.pop_front());
            if (m_hist.size() == 7) begin
                e = 0;
                for (int i = 0; i < 7; i++) if (m_hist[i] != costas[i]) e++;
                if (e <= SME) begin
                    m_locked = 1; m_fpos = 7; m_s1 = e; m_s2 = 0; m_s3 = 0;
                    q_lk.push_back('{idx: n_acc, val: 1'b1});
                end
            end
        end else begin
            f = m_fpos;
            if (f < 36)      m_cw[173-3*(f-7) -: 3] = gray(t);
            else if (f < 43) m_s2 += (t != costas[f-36]) ? 1 : 0;
            else if (f < 72) m_cw[173-3*(f-14) -: 3] = gray(t);
            else             m_s3 += (t != costas[f-72]) ? 1 : 0;
            m_fpos++;
            if (f == 42 && m_s2 > SCE) model_abort();
            if (f == 78) begin
                if (m_s3 > SCE) model_abort();
                else begin
                    q_cw.push_back('{cw: m_cw, idx: n_acc, serr: m_s1 + m_s2 + m_s3});
                    q_lk.push_back('{idx: n_acc, val: 1'b0});
                    m_locked = 0;
                    m_hist.delete();
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic         p_lock = 1'b0, p_valid = 1'b0, p_hs = 1'b0, hold_ok = 1'b1;
    logic [173:0] held = '0;
    cw_exp_t      cur;
    ab_exp_t      ab;
    lk_exp_t      lk;

    always @(negedge clk) begin
        if (!reset_n) begin
            p_lock = 1'b0; p_valid = 1'b0; p_hs = 1'b0;
        end else begin
            if (p_hs) begin
                check("post_hs_cw_valid", cw_valid, 1'b0);
                check("post_hs_sym_ready", sym_ready, 1'b1);
                p_hs = 1'b0;
            end
            if (sync_locked !== p_lock) begin
                if (q_lk.size() == 0) fail_now("lock_unexpected");
                else begin
                    lk = q_lk.pop_front();
                    check("lock_val", sync_locked, lk.val);
                    check("lock_idx", n_acc, lk.idx);
                end
                p_lock = sync_locked;
            end
            if (frame_abort) begin
                if (q_ab.size() == 0) fail_now("abort_unexpected");
                else begin
                    ab = q_ab.pop_front();
                    check("abort_idx", n_acc, ab.idx);
`ifdef FT8_DEFRAME_STATS_EN
                    check("abort_count", abort_count, ab.acnt);
`endif
                end
            end
            if (cw_valid && !p_valid) begin
                hold_ok = 1'b1;
                held    = cw;
                if (q_cw.size() == 0) fail_now("cw_unexpected");
                else begin
                    cur = q_cw.pop_front();
                    check("cw_data", cw, cur.cw);
                    check("cw_idx", n_acc, cur.idx);
                    check("cw_latency", $time - last_acc_t, 5);
`ifdef FT8_DEFRAME_STATS_EN
                    check("sync_err_total", sync_err_total, cur.serr);
`endif
                end
            end
            if (cw_valid) begin
                if (cw !== held || sym_ready !== 1'b0) hold_ok = 1'b0;
                if (cw_ready) begin
                    check("cw_hold", hold_ok, 1'b1);
                    p_hs = 1'b1;
                end
            end
            p_valid = cw_valid;
        end
    end

    // ---------------- stimulus ----------------
    int rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: cw_ready = 1'b1;
            1: cw_ready = 1'b0;
            default: cw_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int fr[79];

    task automatic build_frame(input int a, input int b);
        for (int i = 0; i < 79; i++) begin
            if (i < 7)       fr[i] = costas[i];
            else if (i < 36) fr[i] = (a < 0) ? int'($urandom_range(0, 7)) : a;
            else if (i < 43) fr[i] = costas[i-36];
            else if (i < 72) fr[i] = (b < 0) ? int'($urandom_range(0, 7)) : b;
            else             fr[i] = costas[i-72];
        end
    endtask

    task automatic send_sym(input int t, input int gap);
        for (int g = 0; g < gap; g++) begin
            sym_tone = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        sym_valid = 1'b1;
        sym_tone  = 3'(t);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sym_ready) break;
        end
        if (!sym_ready) begin
            fail_now("sym_ready_timeout");
            sym_valid = 1'b0;
            return;
        end
        @(posedge clk);
        last_acc_t = $time;
        n_acc++;
        model_accept(t);
        #1 sym_valid = 1'b0;
    endtask

    task automatic send_fr(input int from, input int to, input int maxgap);
        for (int i = from; i < to; i++) send_sym(fr[i], int'($urandom_range(0, maxgap)));
    endtask

    task automatic check_reset_vals();
        check("rst_sym_ready", sym_ready, 1'b1);
        check("rst_cw_valid", cw_valid, 1'b0);
        check("rst_cw", cw, 174'd0);
        check("rst_sync_locked", sync_locked, 1'b0);
        check("rst_frame_abort", frame_abort, 1'b0);
`ifdef FT8_DEFRAME_STATS_EN
        check("rst_abort_count", abort_count, 8'd0);
`endif
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        m_locked = 0; m_hist.delete(); m_cw = '0; m_aborts = 0;
        q_cw.delete(); q_ab.delete(); q_lk.delete();
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_idle();
        rdy_mode = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (q_cw.size() == 0 && !cw_valid) break;
        end
        if (q_cw.size() != 0 || cw_valid) fail_now("idle_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        int t, pos, nerr;
        #1;
        do_reset();

        // Clean frame with a constant-derived codeword check.
        build_frame(2, 5);
        send_fr(0, 79, 0);
        check("clean_cw_valid", cw_valid, 1'b1);
        check("clean_cw", cw, CLEAN);
`ifdef FT8_DEFRAME_STATS_EN
        check("clean_err_total", sync_err_total, 5'd0);
`endif
        wait_idle();

        // Ten non-sync tones, then the frame; lock only on the true S1.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            t = int'($urandom_range(0, 7));
            if (t == 3 || t == 1) t = 7;
            send_sym(t, 0);
        end
        send_fr(0, 6, 0);
        check("prefix_no_lock_16", sync_locked, 1'b0);
        send_fr(6, 7, 0);
        check("prefix_lock_17", sync_locked, 1'b1);
        send_fr(7, 79, 0);
        check("prefix_cw", cw, CLEAN);
        wait_idle();

        // S1 with one wrong tone still locks.
        do_reset();
        build_frame(-1, -1);
        fr[3] = 7;
        send_fr(0, 7, 1);
        check("s1_one_err_lock", sync_locked, 1'b1);
        send_fr(7, 79, 1);
        wait_idle();

        // S1 with two wrong tones does not lock.
        do_reset();
        build_frame(-1, -1);
        fr[0] = 0; fr[1] = 0;
        send_fr(0, 7, 0);
        check("s1_two_err_hunt", sync_locked, 1'b0);
        send_fr(7, 79, 0);
        wait_idle();

        // S2 with three wrong tones aborts after frame symbol 43.
        do_reset();
        build_frame(2, 5);
        for (int i = 36; i < 39; i++) fr[i] = (costas[i-36] + 1) % 8;
        send_fr(0, 43, 0);
        check("s2_abort_pulse", frame_abort, 1'b1);
        check("s2_abort_unlock", sync_locked, 1'b0);
        @(posedge clk); #1;
        check("s2_abort_one_cycle", frame_abort, 1'b0);
        build_frame(6, 0);
        send_fr(0, 79, 0);
        wait_idle();

        // Backpressure: codeword held with sym_ready low for 20 cycles.
        do_reset();
        rdy_mode = 1;
        build_frame(-1, -1);
        send_fr(0, 79, 0);
        repeat (20) @(posedge clk);
        #1;
        check("bp_cw_valid", cw_valid, 1'b1);
        check("bp_sym_ready", sym_ready, 1'b0);
        wait_idle();
        check("bp_after_ready", sym_ready, 1'b1);

        // Reset after 40 accepted frame symbols, then a clean frame.
        build_frame(-1, -1);
        send_fr(0, 40, 0);
        do_reset();
        build_frame(2, 5);
        send_fr(0, 79, 0);
        check("post_reset_cw", cw, CLEAN);
        wait_idle();

        // Random frames: random data, sync errors, gaps and cw_ready.
        for (int n = 0; n < 8; n++) begin
            build_frame(-1, -1);
            for (int b = 0; b < 3; b++) begin
                nerr = int'($urandom_range(0, 3));
                for (int e = 0; e < nerr; e++) begin
                    pos = int'($urandom_range(0, 6));
                    fr[b*36 + pos] = (costas[pos] + 1 + int'($urandom_range(0, 6))) % 8;
                end
            end
            rdy_mode = 2;
            send_fr(0, 79, 2);
            repeat (4) @(posedge clk);
            #1;
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        check("q_cw_empty", q_cw.size(), 0);
        check("q_abort_empty", q_ab.size(), 0);
        check("q_lock_empty", q_lk.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
